// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART peripheral: register indices,
// STATUS/CTRL bit positions and the serialiser FSM state type.
package uart_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_BAUD   = 3'd3;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_RX_OVR    = 5;
  localparam int ST_FRAME_ERR = 6;
  localparam int ST_TX_OVF    = 7;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;
  localparam int CTRL_LOOPBACK  = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// 8-bit synchronous first-word-fall-through FIFO; DEPTH must be a power of 2.
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       empty,
  output logic       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot that cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_bus_periph.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs and programmable baud divisor.
// Optional macro UART_LOOPBACK_EN adds CTRL bit 2 (internal TX->RX loopback).
module uart_bus_periph
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk_clk,
  input  logic        rst_reset_n,
  input  logic        bus_enable,
  input  logic        rw,
  input  logic [2:0]  address,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        acknowledge,
  output logic        irq,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  logic        ack_q, acc_we, acc_pop;
  logic [2:0]  acc_addr;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata, rd_mux;
  logic        access, wr_cycle, wr_data, wr_status, wr_ctrl, wr_baud;

  logic [1:0]       irq_en;
  logic             loopback;
  logic [DIV_W-1:0] baud_q, baud_wr;
  logic [31:0]      lane_mask;
  logic             rx_ovr_q, frame_err_q, tx_ovf_q;
  logic [7:0]       status;
  logic [2:0]       ctrl_rd;

  logic       tx_push, tx_pop, tx_empty, tx_full, tx_busy;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;

  uart_state_e      tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic             tx_line_q, tx_line_d, tx_bit_end, rx_bit_end;
  logic             rx_src, rx_s1, rx_s2, rx_s3, rx_fall;
  logic             rx_ovr_set, frame_set, tx_ovf_set;
  logic             unused_bits;

  assign access      = bus_enable & ~ack_q;
  assign acknowledge = ack_q;
  assign wr_cycle    = ack_q & acc_we;
  assign wr_data     = wr_cycle & (acc_addr == REG_DATA) & acc_be[0];
  assign wr_status   = wr_cycle & (acc_addr == REG_STATUS) & acc_be[0];
  assign wr_ctrl     = wr_cycle & (acc_addr == REG_CTRL) & acc_be[0];
  assign wr_baud     = wr_cycle & (acc_addr == REG_BAUD);
  assign rx_pop      = ack_q & acc_pop;
  assign tx_push     = wr_data;
  assign tx_ovf_set  = wr_data & tx_full & ~tx_pop;
  assign tx_busy     = (tx_state_q != IDLE);
  assign unused_bits = ^{acc_wdata, acc_be};

`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n)  loopback <= 1'b0;
    else if (wr_ctrl)  loopback <= acc_wdata[CTRL_LOOPBACK];
  end
`else
  assign loopback = 1'b0;
`endif

  assign rx_src   = loopback ? tx_line_q : uart_rxd;
  assign uart_txd = tx_line_q | loopback;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk_clk), .rst_n(rst_reset_n), .push(tx_push), .push_data(acc_wdata[7:0]),
    .pop(tx_pop), .pop_data(tx_head), .empty(tx_empty), .full(tx_full)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk_clk), .rst_n(rst_reset_n), .push(rx_push), .push_data(rx_sh_q),
    .pop(rx_pop), .pop_data(rx_head), .empty(rx_empty), .full(rx_full)
  );

  // Byte-lane merge of a BAUD write, clamped so every bit lasts at least 2 clocks.
  always_comb begin
    lane_mask = {{8{acc_be[3]}}, {8{acc_be[2]}}, {8{acc_be[1]}}, {8{acc_be[0]}}};
    baud_wr   = (baud_q & ~lane_mask[DIV_W-1:0]) | (acc_wdata[DIV_W-1:0] & lane_mask[DIV_W-1:0]);
    if (baud_wr < DIV_W'(2)) baud_wr = DIV_W'(2);
  end

  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_EMPTY]  = rx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_RX_OVR]    = rx_ovr_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_TX_OVF]    = tx_ovf_q;
    ctrl_rd                 = '0;
    ctrl_rd[CTRL_RX_IRQ_EN] = irq_en[0];
    ctrl_rd[CTRL_TX_IRQ_EN] = irq_en[1];
    ctrl_rd[CTRL_LOOPBACK]  = loopback;
    case (address)
      REG_DATA:   rd_mux = rx_empty ? 32'd0 : {1'b1, 23'd0, rx_head};
      REG_STATUS: rd_mux = {24'd0, status};
      REG_CTRL:   rd_mux = {29'd0, ctrl_rd};
      REG_BAUD:   rd_mux = 32'(baud_q);
      default:    rd_mux = 32'd0;
    endcase
  end

  // The access is latched when sampled; its side effects land in the acknowledge cycle.
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      ack_q     <= 1'b0;
      acc_we    <= 1'b0;
      acc_pop   <= 1'b0;
      acc_addr  <= '0;
      acc_be    <= '0;
      acc_wdata <= '0;
      read_data <= '0;
    end else begin
      ack_q     <= access;
      read_data <= (access & rw) ? rd_mux : 32'd0;
      if (access) begin
        acc_we    <= ~rw;
        acc_pop   <= rw & (address == REG_DATA) & ~rx_empty;
        acc_addr  <= address;
        acc_be    <= byte_enable;
        acc_wdata <= write_data;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      irq_en      <= '0;
      baud_q      <= DIV_W'(DEFAULT_DIV);
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= {acc_wdata[CTRL_TX_IRQ_EN], acc_wdata[CTRL_RX_IRQ_EN]};
      if (wr_baud) baud_q <= baud_wr;
      rx_ovr_q    <= rx_ovr_set | (rx_ovr_q & ~(wr_status & acc_wdata[ST_RX_OVR]));
      frame_err_q <= frame_set | (frame_err_q & ~(wr_status & acc_wdata[ST_FRAME_ERR]));
      tx_ovf_q    <= tx_ovf_set | (tx_ovf_q & ~(wr_status & acc_wdata[ST_TX_OVF]));
      irq         <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty & ~tx_busy)
                   | rx_ovr_q | frame_err_q;
    end
  end

  // TX serialiser: STOP chains straight into START when another byte is queued.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_div_d   = tx_div_q;
    tx_pop     = 1'b0;
    tx_bit_end = (tx_cnt_q == tx_div_q - 1'b1);
    if (tx_state_q != IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      IDLE: if (!tx_empty) begin
        tx_pop = 1'b1; tx_sh_d = tx_head; tx_div_d = baud_q; tx_cnt_d = '0; tx_state_d = START;
      end
      START: if (tx_bit_end) begin
        tx_bit_d = '0; tx_state_d = DATA;
      end
      DATA: if (tx_bit_end) begin
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == 3'd7) tx_state_d = STOP;
      end
      STOP: if (tx_bit_end) begin
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_sh_d = tx_head; tx_div_d = baud_q; tx_state_d = START;
        end else begin
          tx_state_d = IDLE;
        end
      end
    endcase
    case (tx_state_d)
      START:   tx_line_d = 1'b0;
      DATA:    tx_line_d = tx_sh_d[0];
      default: tx_line_d = 1'b1;
    endcase
  end

  // RX deserialiser: mid-bit sampling starting half a bit after the falling edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_div_d   = rx_div_q;
    rx_push    = 1'b0;
    rx_ovr_set = 1'b0;
    frame_set  = 1'b0;
    rx_fall    = rx_s3 & ~rx_s2;
    rx_bit_end = (rx_cnt_q == rx_div_q - 1'b1);
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_div_d = baud_q; rx_state_d = START;
        end
      end
      START: if (rx_cnt_q == (rx_div_q >> 1) - 1'b1) begin
        rx_cnt_d = '0; rx_bit_d = '0;
        rx_state_d = rx_s2 ? IDLE : DATA;
      end
      DATA: if (rx_bit_end) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = STOP;
      end
      STOP: if (rx_bit_end) begin
        rx_cnt_d = '0; rx_state_d = IDLE;
        if (!rx_s2)                  frame_set  = 1'b1;
        else if (rx_full && !rx_pop) rx_ovr_set = 1'b1;
        else                         rx_push    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_div_q   <= DIV_W'(DEFAULT_DIV);
      tx_line_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_div_q   <= DIV_W'(DEFAULT_DIV);
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_div_q   <= tx_div_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_div_q   <= rx_div_d;
      rx_s1      <= rx_src;
      rx_s2      <= rx_s1;
      rx_s3      <= rx_s2;
    end
  end

endmodule

// File: tb/tb_uart_bus_periph.sv
// Directed self-checking bench for uart_bus_periph (default build; loopback
// checks run when UART_LOOPBACK_EN is defined).
module tb_uart_bus_periph;

  logic        clk_clk = 1'b0;
  logic        rst_reset_n;
  logic        bus_enable, rw;
  logic [2:0]  address;
  logic [3:0]  byte_enable;
  logic [31:0] write_data, read_data;
  logic        acknowledge, irq, uart_txd, uart_rxd;

  int errors = 0;
  int checks = 0;
  int tb_div = 4;
  logic [7:0] tx_q [$];

  uart_bus_periph dut (
    .clk_clk(clk_clk), .rst_reset_n(rst_reset_n), .bus_enable(bus_enable), .rw(rw),
    .address(address), .byte_enable(byte_enable), .write_data(write_data),
    .read_data(read_data), .acknowledge(acknowledge), .irq(irq),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic rd_nwr, input logic [2:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd);
    @(posedge clk_clk); #1;
    bus_enable = 1'b1; rw = rd_nwr; address = addr; byte_enable = be; write_data = wd;
    @(posedge clk_clk); #1;
    check("ack_latency", acknowledge, 1);
    rd = read_data;
    bus_enable = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] addr, input logic [31:0] wd, input logic [3:0] be = 4'hF);
    logic [31:0] dummy;
    bus_xfer(1'b0, addr, be, wd, dummy);
  endtask

  task automatic reg_read(input logic [2:0] addr, output logic [31:0] rd);
    bus_xfer(1'b1, addr, 4'h0, 32'd0, rd);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      uart_rxd = f[b];
      repeat (tb_div) @(posedge clk_clk);
      #1;
    end
    uart_rxd = 1'b1;
    repeat (2 * tb_div) @(posedge clk_clk);
    #1;
  endtask

  task automatic wait_tx_low(output logic found);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge clk_clk); #1;
      if (uart_txd === 1'b0) found = 1'b1;
    end
  endtask

  // Decodes every frame seen on uart_txd using the bench's current bit time.
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(posedge clk_clk); #1;
      if (rst_reset_n === 1'b1 && uart_txd === 1'b0) begin
        repeat (tb_div + tb_div / 2) @(posedge clk_clk);
        #1;
        b[0] = uart_txd;
        for (int j = 1; j < 8; j++) begin
          repeat (tb_div) @(posedge clk_clk);
          #1;
          b[j] = uart_txd;
        end
        repeat (tb_div) @(posedge clk_clk);
        tx_q.push_back(b);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] rd;
    logic        found, all_high;
    logic [9:0]  frame;

    rst_reset_n = 1'b0; bus_enable = 1'b0; rw = 1'b0; address = '0;
    byte_enable = '0; write_data = '0; uart_rxd = 1'b1;
    repeat (3) @(posedge clk_clk);
    #1;
    check("rst_read_data", read_data, 0);
    check("rst_ack", acknowledge, 0);
    check("rst_irq", irq, 0);
    check("rst_txd", uart_txd, 1);
    @(negedge clk_clk);
    rst_reset_n = 1'b1;

    reg_read(3'd3, rd); check("baud_reset", rd, 32'd434);
    reg_read(3'd2, rd); check("ctrl_reset", rd, 32'h0);
    reg_read(3'd1, rd); check("status_reset", rd, 32'h06);
    reg_write(3'd3, 32'd1); reg_read(3'd3, rd); check("baud_clamp_1", rd, 32'd2);
    reg_write(3'd3, 32'h0000_0300, 4'b0010); reg_read(3'd3, rd); check("baud_lane1", rd, 32'h0302);
    reg_write(3'd3, 32'd0); reg_read(3'd3, rd); check("baud_clamp_0", rd, 32'd2);
    reg_write(3'd5, 32'hFFFF_FFFF); reg_read(3'd5, rd); check("reg5_read", rd, 32'h0);
    reg_read(3'd3, rd); check("reg5_write_ignored", rd, 32'd2);

    $display("[TB] TX frame 0x55 at div=4");
    reg_write(3'd3, 32'd4);
    reg_write(3'd2, 32'h2);
    tx_q.delete();
    reg_write(3'd0, 32'h55);
    wait_tx_low(found);
    check("tx_start_seen", found, 1);
    frame = {1'b1, 8'h55, 1'b0};
    if (found) begin
      for (int k = 0; k < 40; k++) begin
        check($sformatf("tx_wave_%0d", k), uart_txd, frame[k / 4]);
        if (k == 20) check("irq_low_while_busy", irq, 0);
        @(posedge clk_clk); #1;
      end
    end
    repeat (5) @(posedge clk_clk);
    #1;
    check("irq_tx_idle", irq, 1);
    check("tx_mon_count", tx_q.size(), 1);
    check("tx_mon_byte", (tx_q.size() > 0) ? tx_q[0] : 8'hxx, 8'h55);
    reg_write(3'd2, 32'h0);
    repeat (3) @(posedge clk_clk);
    #1;
    check("irq_cleared", irq, 0);

    $display("[TB] RX byte 0xA3");
    send_frame(8'hA3, 1'b1);
    reg_read(3'd1, rd); check("status_rx_avail", rd, 32'h02);
    reg_read(3'd0, rd); check("rx_data_a3", rd, 32'h8000_00A3);
    reg_read(3'd0, rd); check("rx_data_empty", rd, 32'h0);
    reg_read(3'd1, rd); check("status_rx_drained", rd, 32'h06);

    $display("[TB] RX framing error and glitch");
    send_frame(8'h5A, 1'b0);
    reg_read(3'd1, rd); check("status_frame_err", rd, 32'h46);
    check("irq_frame_err", irq, 1);
    reg_write(3'd1, 32'h40);
    reg_read(3'd1, rd); check("status_frame_w1c", rd, 32'h06);
    reg_read(3'd0, rd); check("frame_err_no_entry", rd, 32'h0);
    uart_rxd = 1'b0;
    @(posedge clk_clk); #1;
    uart_rxd = 1'b1;
    repeat (20) @(posedge clk_clk);
    reg_read(3'd1, rd); check("status_after_glitch", rd, 32'h06);
    reg_read(3'd0, rd); check("glitch_no_entry", rd, 32'h0);

    $display("[TB] RX overrun");
    for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b1);
    reg_read(3'd1, rd); check("status_rx_ovr", rd, 32'h2A);
    check("irq_rx_ovr", irq, 1);
    for (int i = 0; i < 16; i++) begin
      reg_read(3'd0, rd);
      check($sformatf("rx_order_%0d", i), rd, 32'h8000_0010 + 32'(i));
    end
    reg_read(3'd1, rd); check("status_ovr_sticky", rd, 32'h26);
    reg_write(3'd1, 32'h20);
    reg_read(3'd1, rd); check("status_ovr_w1c", rd, 32'h06);
    check("irq_after_ovr_clear", irq, 0);

`ifdef UART_LOOPBACK_EN
    $display("[TB] loopback");
    reg_write(3'd2, 32'h4);
    reg_read(3'd2, rd); check("ctrl_loopback", rd, 32'h4);
    reg_write(3'd0, 32'h3C);
    all_high = 1'b1;
    for (int n = 0; n < 70; n++) begin
      @(posedge clk_clk); #1;
      if (uart_txd !== 1'b1) all_high = 1'b0;
    end
    check("loopback_txd_high", all_high, 1);
    reg_read(3'd0, rd); check("loopback_rx", rd, 32'h8000_003C);
    reg_write(3'd2, 32'h0);
`else
    reg_write(3'd2, 32'h7);
    reg_read(3'd2, rd); check("ctrl_no_loopback", rd, 32'h3);
    reg_write(3'd2, 32'h0);
    all_high = 1'b1;
`endif

    $display("[TB] TX overflow at div=8");
    reg_write(3'd3, 32'd8);
    tb_div = 8;
    tx_q.delete();
    reg_write(3'd0, 32'hE1);
    repeat (4) @(posedge clk_clk);
    reg_read(3'd1, rd); check("status_tx_busy", rd, 32'h16);
    for (int i = 0; i < 17; i++) reg_write(3'd0, 32'h20 + 32'(i));
    reg_read(3'd1, rd); check("status_tx_ovf_full", rd, 32'h95);
    for (int n = 0; n < 3000 && tx_q.size() < 17; n++) @(posedge clk_clk);
    repeat (20) @(posedge clk_clk);
    check("tx_ovf_count", tx_q.size(), 17);
    if (tx_q.size() == 17) begin
      check("tx_inflight", tx_q[0], 8'hE1);
      for (int i = 1; i < 17; i++) check($sformatf("tx_order_%0d", i), tx_q[i], 8'h1F + 8'(i));
    end
    reg_read(3'd1, rd); check("status_tx_ovf_idle", rd, 32'h86);
    reg_write(3'd1, 32'h80);
    reg_read(3'd1, rd); check("status_tx_ovf_w1c", rd, 32'h06);

    $display("[TB] reset mid-frame");
    reg_write(3'd0, 32'h00);
    wait_tx_low(found);
    check("reset_frame_started", found, 1);
    repeat (20) @(posedge clk_clk);
    #1;
    rst_reset_n = 1'b0;
    #1;
    check("reset_txd_high", uart_txd, 1);
    check("reset_irq_low", irq, 0);
    repeat (2) @(negedge clk_clk);
    rst_reset_n = 1'b1;
    all_high = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk_clk); #1;
      if (uart_txd !== 1'b1) all_high = 1'b0;
    end
    check("post_reset_txd_idle", all_high, 1);
    reg_read(3'd1, rd); check("post_reset_status", rd, 32'h06);
    reg_read(3'd3, rd); check("post_reset_baud", rd, 32'd434);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_bus_periph.md
Name: uart_bus_periph

Overview:
- Memory-mapped UART peripheral on the av_uart_external_interface port of the system interconnect.
- Downstream consumer of that interface's bus_enable/rw/address/byte_enable/write_data. Returns read_data, acknowledge and irq.
- Contains TX and RX byte FIFOs, a programmable baud divisor, and an 8N1 serialiser/deserialiser driving the board's UART pins.

Parameters:
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of 2, minimum 2.
- DIV_W, 16, width of the baud divisor register.
- DEFAULT_DIV, 434, reset divisor in clocks per bit (50 MHz / 115200).

Ports:
- clk_clk  in  1  system clock; all logic is on this single clock.
- rst_reset_n  in  1  asynchronous, active-low reset.
- bus_enable  in  1  transfer request; held by the master until acknowledge.
- rw  in  1  1 = read, 0 = write.
- address  in  3  word register index 0..7.
- byte_enable  in  4  write byte lanes.
- write_data  in  32  write data.
- read_data  out  32  read data; valid in the acknowledge cycle.
- acknowledge  out  1  one-cycle completion pulse.
- irq  out  1  level interrupt.
- uart_txd  out  1  serial out; idles high.
- uart_rxd  in  1  serial in; asynchronous to clk_clk.

Behaviour:
- Reset values: read_data=0, acknowledge=0, irq=0, uart_txd=1, FIFOs empty, CTRL=0, BAUD=DEFAULT_DIV, sticky flags=0, TX and RX FSMs in IDLE.
- Bus handshake:
  - acknowledge pulses the cycle after bus_enable is sampled high while acknowledge=0. Latency is 1 cycle and fixed.
  - The cycle in which acknowledge=1 never starts a new access, so back-to-back accesses take 2 cycles each.
  - All register side effects (push, pop, clear) occur exactly once, in the acknowledge cycle.
- Register map (word index):
  - 0 DATA.
    - Write with byte_enable[0]=1 pushes write_data[7:0] into the TX FIFO. If the TX FIFO is full, the byte is dropped and TX_OVF is set.
    - Read returns {valid, 23'b0, byte} and pops the RX FIFO. When the RX FIFO is empty it returns 0 and does not pop.
  - 1 STATUS, read-only except W1C on sticky bits.
    - Bits: 0 tx_full, 1 tx_empty, 2 rx_empty, 3 rx_full, 4 tx_busy.
    - Sticky bits: 5 RX_OVR, 6 FRAME_ERR, 7 TX_OVF.
    - Writing 1 to a sticky bit clears it. A set event in the same cycle wins over the clear.
  - 2 CTRL.
    - Bit 0 rx_irq_en, bit 1 tx_irq_en, bit 2 loopback (see Optional Feature).
    - Written only under byte_enable[0].
  - 3 BAUD.
    - Bits [DIV_W-1:0] hold the divisor, written per enabled lane.
    - A resulting value below 2 is stored as 2.
  - 4..7: read 0; writes ignored; still acknowledged.
- irq = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty & !tx_busy) | RX_OVR | FRAME_ERR. It is a registered output.
- FIFOs:
  - Synchronous, first-word fall-through.
  - Simultaneous push+pop on a full FIFO succeeds on both sides; count is unchanged.
  - Pop on empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- TX FSM, states IDLE, START, DATA, STOP:
  - Leaves IDLE when the FIFO is non-empty; pops one byte and latches the divisor.
  - Each bit lasts exactly `div` clocks. Data is sent LSB first.
  - From STOP, goes to START directly if the FIFO is non-empty, with no idle gap.
  - tx_busy = state != IDLE.
  - BAUD writes take effect at the next frame start.
- RX FSM, states IDLE, START, DATA, STOP:
  - uart_rxd passes through a 2-flop synchroniser.
  - A falling edge in IDLE latches the divisor and waits div/2 clocks, then samples.
  - If the start bit has returned high, the frame is a glitch: return to IDLE, no flag.
  - Data bits are sampled every div clocks.
  - Stop bit low: set FRAME_ERR, discard the byte.
  - Completed byte with the RX FIFO full: set RX_OVR, discard the byte; FIFO contents are unchanged.
- Reset mid-frame: FSMs return to IDLE immediately, uart_txd=1, and the partial byte is lost.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - CTRL bit 2 is implemented.
  - When set, the RX synchroniser input is the internal TX serial stream, and uart_txd is held at 1.
- Undefined:
  - CTRL bit 2 reads 0 and ignores writes.
  - RX always takes uart_rxd.

Decomposition:
- Package uart_pkg:
  - register index constants (REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_BAUD=3);
  - STATUS and CTRL bit-position constants;
  - the TX/RX FSM state enum.
- One sub-module, uart_fifo (parameter DEPTH, 8-bit width), instantiated twice.
- Baud counters and FSMs stay in the top module.

Test Plan:
- Write BAUD=4, then DATA=0x55 -> uart_txd low for 4 clocks, then bits 1,0,1,0,1,0,1,0 of 4 clocks each, then high for 4. tx_busy is 1 throughout; irq rises if tx_irq_en=1.
- Drive rxd with 0xA3 at div=4 -> STATUS rx_empty=0. DATA read returns 0x800000A3, then the next read returns 0x00000000.
- Push 17 bytes with TX FIFO_DEPTH=16 while TX is held busy -> TX_OVF=1 and exactly 16 bytes plus the in-flight byte are transmitted. W1C to STATUS bit 7 -> flag=0.
- Receive 17 bytes without reading -> RX_OVR=1, irq=1. The first 16 bytes read back in order.
- Send a frame with stop bit low -> FRAME_ERR=1, no FIFO entry. Send a 1-clock low glitch -> no flag, no entry.
- With UART_LOOPBACK_EN: CTRL=0x4, write 0x3C -> uart_txd stays 1 and DATA reads 0x8000003C. Without the macro, CTRL reads 0x0.
